// File: rtl/crc_frame_checker.sv
// Serial frame checker: repacks the payload MSB-first into bytes and compares the
// received trailing CRC-16 against one computed serially over the payload.
module crc_frame_checker #(
  parameter int          FRAME_BITS = 128,
  parameter logic [15:0] CRC_POLY   = 16'h1021,
  parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       flush,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_done,
  output logic       crc_ok,
  output logic [7:0] err_count
);

  localparam int CW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] LAST_PAY = CW'(FRAME_BITS - 17);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

  localparam logic [1:0] S_PAYLOAD = 2'd0;
  localparam logic [1:0] S_CRC     = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   crc_q, crc_d, rx_q, rx_d, crc_upd, rx_next;
  logic [6:0]    pack_q, pack_d;
  logic [7:0]    byte_q, byte_d, err_q, err_d;
  logic          bvld_q, bvld_d, done_q, done_d, ok_q, ok_d;

  assign crc_upd = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_in) ? CRC_POLY : 16'h0000);
  assign rx_next = {rx_q[14:0], bit_in};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    rx_d    = rx_q;
    pack_d  = pack_q;
    byte_d  = byte_q;
    err_d   = err_q;
    ok_d    = ok_q;
    bvld_d  = 1'b0;
    done_d  = 1'b0;
    if (flush) begin
      state_d = S_PAYLOAD;
      cnt_d   = '0;
      crc_d   = CRC_INIT;
      pack_d  = '0;
    end else begin
      if (state_q == S_DONE) state_d = S_PAYLOAD;
      if (bit_valid) begin
        if (state_q == S_CRC) begin
          rx_d = rx_next;
          if (cnt_q == LAST_BIT) begin
            // Frame closes here; DONE already carries a fresh CRC so its bit starts the next frame
            state_d = S_DONE;
            cnt_d   = '0;
            crc_d   = CRC_INIT;
            done_d  = 1'b1;
            ok_d    = (rx_next == crc_q);
            if (rx_next != crc_q && err_q != 8'hFF) err_d = err_q + 8'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          crc_d  = crc_upd;
          pack_d = {pack_q[5:0], bit_in};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q[2:0] == 3'd7) begin
            byte_d = {pack_q, bit_in};
            bvld_d = 1'b1;
          end
          if (cnt_q == LAST_PAY) state_d = S_CRC;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_PAYLOAD;
      cnt_q   <= '0;
      crc_q   <= CRC_INIT;
      rx_q    <= '0;
      pack_q  <= '0;
      byte_q  <= '0;
      err_q   <= '0;
      ok_q    <= 1'b0;
      bvld_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
      pack_q  <= pack_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
      bvld_q  <= bvld_d;
      done_q  <= done_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = bvld_q;
  assign frame_done = done_q;
  assign crc_ok     = ok_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Random-stimulus bench for crc_frame_checker: an 88-bit and a 128-bit instance,
// checked against a bytewise CRC-16 reference model and expected byte/verdict queues.
module tb_crc_frame_checker;

  logic clk = 1'b0;
  logic reset, bit_in, bit_valid, flush, sel;
  always #5 clk = ~clk;

  logic [7:0] bo0, ec0, bo1, ec1;
  logic       bv0, fd0, ok0, bv1, fd1, ok1;

  crc_frame_checker #(.FRAME_BITS(88)) dut0 (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid & ~sel),
    .flush(flush & ~sel), .byte_out(bo0), .byte_valid(bv0), .frame_done(fd0),
    .crc_ok(ok0), .err_count(ec0));

  crc_frame_checker #(.FRAME_BITS(128)) dut1 (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid & sel),
    .flush(flush & sel), .byte_out(bo1), .byte_valid(bv1), .frame_done(fd1),
    .crc_ok(ok1), .err_count(ec1));

  wire [7:0] bom = sel ? bo1 : bo0;
  wire [7:0] ecm = sel ? ec1 : ec0;
  wire       bvm = sel ? bv1 : bv0;
  wire       fdm = sel ? fd1 : fd0;
  wire       okm = sel ? ok1 : ok0;

  int n_cmp = 0, n_err = 0, collide = 0;
  int exp_err [2];
  logic [7:0] pay[$], exp_b[$], got_b[$];
  bit         frm[$], exp_ok[$], got_ok[$];

  always @(negedge clk) begin
    if (bv0 || bv1) got_b.push_back(bom);
    if (fd0 || fd1) got_ok.push_back(okm);
    if ((bv0 && fd0) || (bv1 && fd1)) collide++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic f);
    bit_valid = v; bit_in = b; flush = f;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] crc_bytes(input logic [7:0] d[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (d[i]) begin
      c = c ^ {d[i], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Queue one frame from pay: optional payload bit flip and/or corrupted CRC field.
  task automatic build(input int flip, input bit bad);
    logic [7:0]  tx[$];
    logic [7:0]  t;
    logic [15:0] c_tx, c_sent;
    tx = pay;
    if (flip >= 0) begin
      t = tx[flip / 8];
      t[7 - (flip % 8)] = ~t[7 - (flip % 8)];
      tx[flip / 8] = t;
    end
    c_tx   = crc_bytes(tx);
    c_sent = crc_bytes(pay) ^ (bad ? 16'($urandom_range(1, 65535)) : 16'h0000);
    foreach (tx[i]) begin
      for (int k = 7; k >= 0; k--) frm.push_back(tx[i][k]);
      exp_b.push_back(tx[i]);
    end
    for (int k = 15; k >= 0; k--) frm.push_back(c_sent[k]);
    exp_ok.push_back(c_tx == c_sent);
    if (c_tx != c_sent && exp_err[sel] != 255) exp_err[sel]++;
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    repeat (n) pay.push_back(8'($urandom));
  endtask

  task automatic ascii_pay();
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
  endtask

  task automatic send(input int gap);
    foreach (frm[i]) begin
      while ($urandom_range(0, 99) < gap) drive(1'b0, 1'($urandom), 1'b0);
      drive(1'b1, frm[i], 1'b0);
    end
    frm.delete();
  endtask

  task automatic finish_test(input string tag);
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    check({tag, "_nbytes"}, got_b.size(), exp_b.size());
    foreach (exp_b[i]) if (i < got_b.size()) check({tag, "_byte"}, got_b[i], exp_b[i]);
    check({tag, "_ndone"}, got_ok.size(), exp_ok.size());
    foreach (exp_ok[i]) if (i < got_ok.size()) check({tag, "_crc_ok"}, got_ok[i], exp_ok[i]);
    check({tag, "_err_count"}, ecm, exp_err[sel]);
    exp_b.delete(); got_b.delete(); exp_ok.delete(); got_ok.delete();
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1; exp_err[0] = 0; exp_err[1] = 0;
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check("rst_byte_out", {bo0, bo1}, 16'h0);
    check("rst_strobes", {bv0, fd0, bv1, fd1}, 4'h0);
    check("rst_crc_ok", {ok0, ok1}, 2'b00);
    check("rst_err_count", {ec0, ec1}, 16'h0);

    // 88-bit reference frame, then a payload-bit error
    ascii_pay(); build(-1, 1'b0); send(0); finish_test("t1_good");
    ascii_pay(); build(5, 1'b0); send(0); finish_test("t2_flip");

    // three back-to-back 128-bit frames with mixed verdicts
    sel = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_pay(14);
      case ($urandom_range(0, 2))
        0: build(-1, 1'b0);
        1: build(-1, 1'b1);
        default: build($urandom_range(0, 111), 1'b0);
      endcase
    end
    send(0); finish_test("t3_b2b");
    sel = 1'b0;

    ascii_pay(); build(-1, 1'b0); send(30); finish_test("t4_gaps");

    // abort after 40 bits with a concurrent valid bit that must be dropped
    rand_pay(5);
    foreach (pay[i]) begin
      for (int k = 7; k >= 0; k--) frm.push_back(pay[i][k]);
      exp_b.push_back(pay[i]);
    end
    send(0);
    drive(1'b1, 1'($urandom), 1'b1);
    check("t5_ok_held", ok0, 1'b1);
    check("t5_err_held", ec0, 8'(exp_err[0]));
    ascii_pay(); build(-1, 1'b0); send(0); finish_test("t5_flush");

    // reset mid-frame, then a good frame and 300 bad ones
    ascii_pay(); build(-1, 1'b0);
    frm = frm[0:59];
    send(0);
    exp_b.delete();
    exp_ok.delete();
    reset = 1'b1; drive(1'b0, 1'b0, 1'b0); reset = 1'b0;
    exp_err[0] = 0; exp_err[1] = 0;
    check("t6_rst_ok", ok0, 1'b0);
    check("t6_rst_err", ec0, 8'h00);
    check("t6_rst_strobes", {bv0, fd0}, 2'b00);
    got_b.delete(); got_ok.delete();
    ascii_pay(); build(-1, 1'b0); send(0); finish_test("t6_after_rst");
    for (int f = 0; f < 300; f++) begin
      rand_pay(9); build(-1, 1'b1); send(0);
    end
    finish_test("t6_sat");
    check("t6_err_ff", ec0, 8'hFF);
    check("strobe_overlap", collide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
